// File: rtl/cdnsdru_usb4_message_bus_mac_io_recal_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cdnsdru_usb4_mb_pkg                                            |
// | Brief   : Shared MB IORecal state encoding and retry limit.              |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package cdnsdru_usb4_mb_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      REQ_WR_START = 3'd1,
      REQ_WR       = 3'd2,
      WAIT_DONE    = 3'd3,
      DONE         = 3'd4
   } mb_iorecal_state_e;

   localparam int unsigned MB_IORECAL_MAX_RETRY = 2;

endpackage
`default_nettype wire

// File: rtl/cdnsdru_usb4_message_bus_mac_io_recal_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : cdnsdru_usb4_message_bus_mac_io_recal_ctrl_if                |
// | Brief     : MB RX/TX controller handshake seen by the IORecal control.   |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface cdnsdru_usb4_message_bus_mac_io_recal_ctrl_if;

   logic rx_phyiorecalreq;
   logic rx_iorecaldone;
   logic iorecalreq_sent;
   logic prio_tx_write_done;
   logic iorecalreq_tx_write;

   // master = MB register RX/TX controllers, slave = IORecal control
   modport master (
      output rx_phyiorecalreq,
      output rx_iorecaldone,
      output iorecalreq_sent,
      output prio_tx_write_done,
      input  iorecalreq_tx_write
   );

   modport slave (
      input  rx_phyiorecalreq,
      input  rx_iorecaldone,
      input  iorecalreq_sent,
      input  prio_tx_write_done,
      output iorecalreq_tx_write
   );

endinterface
`default_nettype wire

// File: rtl/cdnsdru_usb4_mb_timeout_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cdnsdru_usb4_mb_timeout_timer                                   |
// | Brief  : Clearable saturating up-counter with terminal-count compare.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module cdnsdru_usb4_mb_timeout_timer #(
   parameter int unsigned TERM_CNT = 65535,
   parameter int unsigned TMR_W    = 20
) (
   input  wire  pipe_mac2phy_clk,
   input  wire  pipe_mac2phy_rstn,
   input  wire  clr,
   input  wire  en,
   output logic tc
);

   localparam logic [TMR_W-1:0] C_TC_VAL  = TMR_W'(TERM_CNT - 1);
   localparam logic [TMR_W-1:0] C_SAT_VAL = {TMR_W{1'b1}};

   logic [TMR_W-1:0] count_q;
   logic [TMR_W-1:0] count_d;

   // Clear has priority; the count holds at all-ones instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != C_SAT_VAL)) begin
         count_d = count_q + TMR_W'(1);
      end
   end

   always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
      if (!pipe_mac2phy_rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == C_TC_VAL);

endmodule
`default_nettype wire

// File: rtl/cdnsdru_usb4_message_bus_mac_io_recal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cdnsdru_usb4_message_bus_mac_io_recal_ctrl                      |
// | Brief  : MAC-side IORecal sequencer: request write, wait for PHY done.   |
// | Option : CDNSDRU_USB4_MB_IORECAL_RETRY_EN adds timeout retries.          |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module cdnsdru_usb4_message_bus_mac_io_recal_ctrl
   import cdnsdru_usb4_mb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned TMR_W          = 20
) (
   input  wire         pipe_mac2phy_clk,
   input  wire         pipe_mac2phy_rstn,
   input  wire         mb_enable,
   input  wire         cdb_reset,
   input  wire         cdb_ctrl_reset,
   input  wire         mac_recal_req,
   cdnsdru_usb4_message_bus_mac_io_recal_ctrl_if.slave mb,
   output logic        recal_busy,
   output logic        recal_done,
   output logic        recal_timeout,
   output logic        spurious_done,
   output logic        phy_req_pending
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
   ,
   output logic [1:0]  retry_cnt
`endif
);

   mb_iorecal_state_e state_q, state_d;
   logic              pending_q, pending_d;
   logic              timeout_q, timeout_d;
   logic              spurious_q, spurious_d;
   logic              soft_rst;
   logic              tmr_tc;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
   logic [1:0]        retry_cnt_q, retry_cnt_d;
`endif

   assign soft_rst = ~mb_enable | cdb_reset | cdb_ctrl_reset;

   cdnsdru_usb4_mb_timeout_timer #(
      .TERM_CNT (TIMEOUT_CYCLES),
      .TMR_W    (TMR_W)
   ) u_timer (
      .pipe_mac2phy_clk  (pipe_mac2phy_clk),
      .pipe_mac2phy_rstn (pipe_mac2phy_rstn),
      .clr               (soft_rst | (state_q != WAIT_DONE)),
      .en                (state_q == WAIT_DONE),
      .tc                (tmr_tc)
   );

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      timeout_d  = 1'b0;
      spurious_d = 1'b0;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
      retry_cnt_d = retry_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pending_q || mac_recal_req) begin
               state_d   = REQ_WR_START;
               pending_d = 1'b0;
            end
         end
         REQ_WR_START: begin
            if (mb.iorecalreq_sent) state_d = REQ_WR;
         end
         REQ_WR: begin
            if (mb.prio_tx_write_done) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            // Done on the terminal cycle wins over the timeout.
            if (mb.rx_iorecaldone) begin
               state_d = DONE;
            end else if (tmr_tc) begin
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
               if (retry_cnt_q < 2'(MB_IORECAL_MAX_RETRY)) begin
                  state_d     = REQ_WR_START;
                  retry_cnt_d = retry_cnt_q + 2'd1;
               end else begin
                  state_d   = IDLE;
                  timeout_d = 1'b1;
               end
`else
               state_d   = IDLE;
               timeout_d = 1'b1;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A new PHY request in the same cycle as the clear must not be lost.
      if (mb.rx_phyiorecalreq) pending_d = 1'b1;
      if (mb.rx_iorecaldone && (state_q != WAIT_DONE)) spurious_d = 1'b1;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
      if (state_d == IDLE) retry_cnt_d = 2'd0;
`endif

      if (soft_rst) begin
         state_d    = IDLE;
         pending_d  = 1'b0;
         timeout_d  = 1'b0;
         spurious_d = 1'b0;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
         retry_cnt_d = 2'd0;
`endif
      end
   end

   always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
      if (!pipe_mac2phy_rstn) begin
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         timeout_q  <= 1'b0;
         spurious_q <= 1'b0;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
         retry_cnt_q <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         timeout_q  <= timeout_d;
         spurious_q <= spurious_d;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

   assign mb.iorecalreq_tx_write = (state_q == REQ_WR_START) || (state_q == REQ_WR);
   assign recal_busy             = (state_q != IDLE);
   assign recal_done             = (state_q == DONE);
   assign recal_timeout          = timeout_q;
   assign spurious_done          = spurious_q;
   assign phy_req_pending        = pending_q;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
   assign retry_cnt              = retry_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdnsdru_usb4_message_bus_mac_io_recal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_cdnsdru_usb4_message_bus_mac_io_recal_ctrl                   |
// | Brief  : Directed bench for the MAC IORecal sequencer (TIMEOUT=16).      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_cdnsdru_usb4_message_bus_mac_io_recal_ctrl;

   logic clk;
   logic rstn;
   logic mb_enable;
   logic cdb_reset;
   logic cdb_ctrl_reset;
   logic mac_recal_req;
   logic recal_busy;
   logic recal_done;
   logic recal_timeout;
   logic spurious_done;
   logic phy_req_pending;
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
   logic [1:0] retry_cnt;
`endif

   int total;
   int bad;

   cdnsdru_usb4_message_bus_mac_io_recal_ctrl_if mb_if ();

   cdnsdru_usb4_message_bus_mac_io_recal_ctrl #(
      .TIMEOUT_CYCLES (16),
      .TMR_W          (20)
   ) dut (
      .pipe_mac2phy_clk  (clk),
      .pipe_mac2phy_rstn (rstn),
      .mb_enable         (mb_enable),
      .cdb_reset         (cdb_reset),
      .cdb_ctrl_reset    (cdb_ctrl_reset),
      .mac_recal_req     (mac_recal_req),
      .mb                (mb_if),
      .recal_busy        (recal_busy),
      .recal_done        (recal_done),
      .recal_timeout     (recal_timeout),
      .spurious_done     (spurious_done),
      .phy_req_pending   (phy_req_pending)
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
      ,
      .retry_cnt         (retry_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Stimulus only: mac request, sent, write_done -> WAIT_DONE entered.
   task automatic drive_to_wait_done();
      mac_recal_req = 1'b1; tick();
      mac_recal_req = 1'b0;
      mb_if.iorecalreq_sent = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b0;
      mb_if.prio_tx_write_done = 1'b1; tick();
      mb_if.prio_tx_write_done = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick(3);
      total++;
      if ({mb_if.iorecalreq_tx_write, recal_busy, recal_done, recal_timeout,
           spurious_done, phy_req_pending} !== 6'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 000000",
                  {mb_if.iorecalreq_tx_write, recal_busy, recal_done, recal_timeout,
                   spurious_done, phy_req_pending});
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_basic_flow();
      mb_if.rx_phyiorecalreq = 1'b1; tick();
      mb_if.rx_phyiorecalreq = 1'b0;
      total++;
      if (phy_req_pending !== 1'b1 || mb_if.iorecalreq_tx_write !== 1'b0) begin
         bad++;
         $display("FAIL basic_pending: pending=%b tx_write=%b want 1 0",
                  phy_req_pending, mb_if.iorecalreq_tx_write);
      end
      tick();
      total++;
      if (mb_if.iorecalreq_tx_write !== 1'b1 || phy_req_pending !== 1'b0 || recal_busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_tx_write: tx_write=%b pending=%b busy=%b want 1 0 1",
                  mb_if.iorecalreq_tx_write, phy_req_pending, recal_busy);
      end
      mb_if.iorecalreq_sent = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b0;
      tick(2);
      total++;
      if (mb_if.iorecalreq_tx_write !== 1'b1) begin
         bad++;
         $display("FAIL basic_req_wr_hold: tx_write=%b want 1", mb_if.iorecalreq_tx_write);
      end
      mb_if.prio_tx_write_done = 1'b1; tick();
      mb_if.prio_tx_write_done = 1'b0;
      total++;
      if (mb_if.iorecalreq_tx_write !== 1'b0 || recal_busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_wait_done: tx_write=%b busy=%b want 0 1",
                  mb_if.iorecalreq_tx_write, recal_busy);
      end
      tick(9);
      mb_if.rx_iorecaldone = 1'b1; tick();
      mb_if.rx_iorecaldone = 1'b0;
      total++;
      if (recal_done !== 1'b1 || recal_timeout !== 1'b0 || spurious_done !== 1'b0) begin
         bad++;
         $display("FAIL basic_done: done=%b timeout=%b spurious=%b want 1 0 0",
                  recal_done, recal_timeout, spurious_done);
      end
      tick();
      total++;
      if (recal_done !== 1'b0 || recal_busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle: done=%b busy=%b want 0 0", recal_done, recal_busy);
      end
   endtask

   task automatic test_timeout();
      drive_to_wait_done();
      tick(15);
      total++;
      if (recal_timeout !== 1'b0 || recal_busy !== 1'b1) begin
         bad++;
         $display("FAIL timeout_early: timeout=%b busy=%b want 0 1", recal_timeout, recal_busy);
      end
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
      // Retried attempt: abort it with a done so the bench returns to IDLE.
      tick();
      total++;
      if (recal_timeout !== 1'b0 || mb_if.iorecalreq_tx_write !== 1'b1 || retry_cnt !== 2'd1) begin
         bad++;
         $display("FAIL timeout_retry: timeout=%b tx_write=%b retry=%0d want 0 1 1",
                  recal_timeout, mb_if.iorecalreq_tx_write, retry_cnt);
      end
      mb_if.iorecalreq_sent = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b0;
      mb_if.prio_tx_write_done = 1'b1; tick();
      mb_if.prio_tx_write_done = 1'b0;
      mb_if.rx_iorecaldone = 1'b1; tick();
      mb_if.rx_iorecaldone = 1'b0;
      tick();
`else
      tick();
      total++;
      if (recal_timeout !== 1'b1 || recal_busy !== 1'b0 || recal_done !== 1'b0) begin
         bad++;
         $display("FAIL timeout_pulse: timeout=%b busy=%b done=%b want 1 0 0",
                  recal_timeout, recal_busy, recal_done);
      end
      tick();
      total++;
      if (recal_timeout !== 1'b0) begin
         bad++;
         $display("FAIL timeout_one_cycle: timeout=%b want 0", recal_timeout);
      end
`endif
   endtask

   task automatic test_done_at_terminal();
      drive_to_wait_done();
      tick(15);
      mb_if.rx_iorecaldone = 1'b1; tick();
      mb_if.rx_iorecaldone = 1'b0;
      total++;
      if (recal_done !== 1'b1 || recal_timeout !== 1'b0) begin
         bad++;
         $display("FAIL terminal_done_wins: done=%b timeout=%b want 1 0", recal_done, recal_timeout);
      end
      tick();
   endtask

   task automatic test_pending_midseq();
      drive_to_wait_done();
      tick(2);
      mb_if.rx_phyiorecalreq = 1'b1; tick();
      mb_if.rx_phyiorecalreq = 1'b0;
      total++;
      if (phy_req_pending !== 1'b1 || mb_if.iorecalreq_tx_write !== 1'b0) begin
         bad++;
         $display("FAIL midseq_pending: pending=%b tx_write=%b want 1 0",
                  phy_req_pending, mb_if.iorecalreq_tx_write);
      end
      // Handshake strobes outside their own states must have no effect.
      mb_if.iorecalreq_sent = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b0;
      mb_if.rx_iorecaldone = 1'b1; tick();
      mb_if.rx_iorecaldone = 1'b0;
      tick();
      total++;
      if (recal_busy !== 1'b0 || phy_req_pending !== 1'b1) begin
         bad++;
         $display("FAIL midseq_idle: busy=%b pending=%b want 0 1", recal_busy, phy_req_pending);
      end
      tick();
      total++;
      if (mb_if.iorecalreq_tx_write !== 1'b1 || phy_req_pending !== 1'b0) begin
         bad++;
         $display("FAIL midseq_restart: tx_write=%b pending=%b want 1 0",
                  mb_if.iorecalreq_tx_write, phy_req_pending);
      end
      mb_if.iorecalreq_sent = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b0;
      mb_if.prio_tx_write_done = 1'b1; tick();
      mb_if.prio_tx_write_done = 1'b0;
      mb_if.rx_iorecaldone = 1'b1; tick();
      mb_if.rx_iorecaldone = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      mac_recal_req = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b0;
      mb_if.prio_tx_write_done = 1'b1; tick();
      mb_if.prio_tx_write_done = 1'b0;
      mb_if.rx_iorecaldone = 1'b1; tick();
      mb_if.rx_iorecaldone = 1'b0;
      tick();
      total++;
      if (recal_busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle: busy=%b want 0", recal_busy);
      end
      tick();
      total++;
      if (mb_if.iorecalreq_tx_write !== 1'b1 || recal_busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_restart: tx_write=%b busy=%b want 1 1",
                  mb_if.iorecalreq_tx_write, recal_busy);
      end
      mac_recal_req = 1'b0;
   endtask

   task automatic test_soft_reset();
      // Arrive in REQ_WR (from the REQ_WR_START left by the previous task).
      mb_if.iorecalreq_sent = 1'b1; tick();
      mb_if.iorecalreq_sent = 1'b0;
      mb_if.rx_phyiorecalreq = 1'b1;
      cdb_ctrl_reset = 1'b1; tick();
      mb_if.rx_phyiorecalreq = 1'b0;
      cdb_ctrl_reset = 1'b0;
      total++;
      if ({mb_if.iorecalreq_tx_write, recal_busy, recal_done, recal_timeout,
           spurious_done, phy_req_pending} !== 6'b0) begin
         bad++;
         $display("FAIL softrst_outputs: got %b want 000000",
                  {mb_if.iorecalreq_tx_write, recal_busy, recal_done, recal_timeout,
                   spurious_done, phy_req_pending});
      end
      tick(3);
      mb_if.rx_iorecaldone = 1'b1; tick();
      mb_if.rx_iorecaldone = 1'b0;
      total++;
      if (spurious_done !== 1'b1 || recal_done !== 1'b0 || recal_busy !== 1'b0) begin
         bad++;
         $display("FAIL spurious_pulse: spurious=%b done=%b busy=%b want 1 0 0",
                  spurious_done, recal_done, recal_busy);
      end
      tick();
      total++;
      if (spurious_done !== 1'b0) begin
         bad++;
         $display("FAIL spurious_one_cycle: spurious=%b want 0", spurious_done);
      end
      // mb_enable low is also a soft reset.
      mac_recal_req = 1'b1; tick();
      mac_recal_req = 1'b0;
      mb_enable = 1'b0; tick();
      mb_enable = 1'b1;
      total++;
      if (recal_busy !== 1'b0 || mb_if.iorecalreq_tx_write !== 1'b0) begin
         bad++;
         $display("FAIL mb_enable_abort: busy=%b tx_write=%b want 0 0",
                  recal_busy, mb_if.iorecalreq_tx_write);
      end
   endtask

`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
   task automatic test_retry();
      mac_recal_req = 1'b1; tick();
      mac_recal_req = 1'b0;
      for (int a = 0; a < 3; a++) begin
         total++;
         if (mb_if.iorecalreq_tx_write !== 1'b1 || retry_cnt !== 2'(a)) begin
            bad++;
            $display("FAIL retry_attempt%0d: tx_write=%b retry=%0d want 1 %0d",
                     a, mb_if.iorecalreq_tx_write, retry_cnt, a);
         end
         mb_if.iorecalreq_sent = 1'b1; tick();
         mb_if.iorecalreq_sent = 1'b0;
         mb_if.prio_tx_write_done = 1'b1; tick();
         mb_if.prio_tx_write_done = 1'b0;
         tick(16);
         total++;
         if (recal_timeout !== ((a == 2) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL retry_timeout%0d: timeout=%b want %0d", a, recal_timeout, (a == 2));
         end
      end
      total++;
      if (recal_busy !== 1'b0 || retry_cnt !== 2'd0) begin
         bad++;
         $display("FAIL retry_final_idle: busy=%b retry=%0d want 0 0", recal_busy, retry_cnt);
      end
      tick();
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rstn  = 1'b0;
      mb_enable      = 1'b1;
      cdb_reset      = 1'b0;
      cdb_ctrl_reset = 1'b0;
      mac_recal_req  = 1'b0;
      mb_if.rx_phyiorecalreq   = 1'b0;
      mb_if.rx_iorecaldone     = 1'b0;
      mb_if.iorecalreq_sent    = 1'b0;
      mb_if.prio_tx_write_done = 1'b0;

      test_reset();
      test_basic_flow();
      test_timeout();
      test_done_at_terminal();
      test_pending_midseq();
      test_back_to_back();
      test_soft_reset();
`ifdef CDNSDRU_USB4_MB_IORECAL_RETRY_EN
      test_retry();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
